// File: rtl/mlx_frame_sequencer.sv
// MLX90640 full-frame readout sequencer: polls status, streams RAM words to the
// frame buffer, then clears the data-ready flag through the shared I2C master.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// POLL_REQ  | status read presented to the I2C master
// POLL_WAIT | status read outstanding
// GAP       | idle spacing before the next status poll
// READ_REQ  | RAM word read presented
// READ_WAIT | RAM word read outstanding; response streams out as a pixel
// CLR_REQ   | status write (data-ready cleared) presented
// CLR_WAIT  | status write outstanding; frame_done follows its response
module mlx_frame_sequencer #(
   parameter logic [6:0]  DEV_ADDR    = 7'h33,
   parameter logic [15:0] RAM_BASE    = 16'h0400,
   parameter int unsigned WORDS       = 832,
   parameter logic [15:0] STATUS_ADDR = 16'h8000,
   parameter int unsigned POLL_GAP    = 2000,
   parameter int unsigned RSP_TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_write,
   output logic [6:0]  cmd_dev,
   output logic [15:0] cmd_reg,
   output logic [15:0] cmd_wdata,
   input  logic        rsp_valid,
   input  logic [15:0] rsp_data,
   input  logic        rsp_nack,
   output logic        pix_valid,
   output logic [9:0]  pix_index,
   output logic [15:0] pix_data,
   output logic        subpage,
   output logic        busy,
   output logic        frame_done,
   output logic        error
);

   localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(RSP_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
   localparam logic [9:0]    LAST_IDX = 10'(WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, POLL_REQ, POLL_WAIT, GAP, READ_REQ, READ_WAIT, CLR_REQ, CLR_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    idx_q, idx_d;
   logic [15:0]   status_q, status_d;
   logic          subpage_q, subpage_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          abort_q, abort_d;
   logic          done_q, done_d;
   logic          in_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         status_q  <= '0;
         subpage_q <= 1'b0;
         tmo_q     <= '0;
         gap_q     <= '0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         status_q  <= status_d;
         subpage_q <= subpage_d;
         tmo_q     <= tmo_d;
         gap_q     <= gap_d;
         abort_q   <= abort_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      status_d  = status_q;
      subpage_d = subpage_q;
      tmo_d     = tmo_q;
      gap_d     = gap_q;
      abort_d   = abort_q;
      done_d    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_dev   = '0;
      cmd_reg   = '0;
      cmd_wdata = '0;
      pix_valid = 1'b0;
      pix_index = '0;
      pix_data  = '0;
      error     = 1'b0;
      in_wait   = (state_q == POLL_WAIT) || (state_q == READ_WAIT) || (state_q == CLR_WAIT);

      case (state_q)
         IDLE: begin
            if (start && !abort) state_d = POLL_REQ;
         end
         POLL_REQ, READ_REQ, CLR_REQ: begin
            cmd_valid = 1'b1;
            cmd_dev   = DEV_ADDR;
            if (state_q == READ_REQ) begin
               cmd_reg = RAM_BASE + {6'd0, idx_q};
            end else begin
               cmd_reg = STATUS_ADDR;
            end
            if (state_q == CLR_REQ) begin
               cmd_write = 1'b1;
               cmd_wdata = status_q & 16'hFFF7;
            end
            // An abort coinciding with acceptance still owes us a response.
            if (cmd_ready) begin
               tmo_d   = TMO_LOAD;
               abort_d = abort;
               case (state_q)
                  POLL_REQ: state_d = POLL_WAIT;
                  READ_REQ: state_d = READ_WAIT;
                  default:  state_d = CLR_WAIT;
               endcase
            end else if (abort) begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (abort) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               state_d = POLL_REQ;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: ;
      endcase

      if (in_wait) begin
         if (rsp_valid && rsp_nack) begin
            error   = 1'b1;
            state_d = IDLE;
         end else if (rsp_valid) begin
            if (abort_q || abort) begin
               state_d = IDLE;
            end else begin
               case (state_q)
                  POLL_WAIT: begin
                     if (rsp_data[3]) begin
                        status_d  = rsp_data;
                        subpage_d = rsp_data[0];
                        idx_d     = '0;
                        state_d   = READ_REQ;
                     end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                     end
                  end
                  READ_WAIT: begin
                     pix_valid = 1'b1;
                     pix_index = idx_q;
                     pix_data  = rsp_data;
                     if (idx_q == LAST_IDX) begin
                        state_d = CLR_REQ;
                     end else begin
                        idx_d   = idx_q + 10'd1;
                        state_d = READ_REQ;
                     end
                  end
                  default: begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               endcase
            end
         end else if (tmo_q == '0) begin
            error   = 1'b1;
            state_d = IDLE;
         end else begin
            tmo_d = tmo_q - TW'(1);
            if (abort) abort_d = 1'b1;
         end
      end

      if (state_d == IDLE) abort_d = 1'b0;
   end

   assign subpage    = subpage_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;

endmodule

// File: doc/mlx_frame_sequencer.md
Name: mlx_frame_sequencer

Overview:
- Sequences full-frame readout of the MLX90640 thermal sensor through the shared I2C master (SDA/SCL on IO21/IO22).
- On request it polls the status register until new data is flagged, reads the 832 RAM words one word at a time, and streams them to the frame buffer with their word index. It then clears the data-ready flag.
- It is the only requester on the sensor's I2C command port.

Parameters:
- DEV_ADDR, 7'h33: 7-bit I2C device address.
- RAM_BASE, 16'h0400: first RAM word address.
- WORDS, 832: words per subpage frame; range 1..1023.
- STATUS_ADDR, 16'h8000: status register address.
- POLL_GAP, 2000: idle cycles between consecutive status polls; must be ≥1.
- RSP_TIMEOUT, 100000: maximum cycles from command acceptance to response.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: frame request pulse; ignored unless idle.
- abort, in, 1: return to idle once the outstanding response (if any) arrives.
- cmd_valid, out, 1: command request to the I2C master.
- cmd_ready, in, 1: I2C master accepts the command.
- cmd_write, out, 1: 1 = word write, 0 = word read.
- cmd_dev, out, 7: device address; always DEV_ADDR.
- cmd_reg, out, 16: register address.
- cmd_wdata, out, 16: write data.
- rsp_valid, in, 1: one-cycle response pulse.
- rsp_data, in, 16: read data, valid with rsp_valid.
- rsp_nack, in, 1: transaction NACKed, valid with rsp_valid.
- pix_valid, out, 1: one-cycle pixel word strobe.
- pix_index, out, 10: word index 0..WORDS-1.
- pix_data, out, 16: raw RAM word.
- subpage, out, 1: status[0] captured at frame start.
- busy, out, 1: high in any state except IDLE.
- frame_done, out, 1: one-cycle pulse when the frame completes.
- error, out, 1: one-cycle pulse on NACK or timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Command handshake:
  - cmd_valid with cmd_* fields held stable until the cycle where cmd_valid && cmd_ready.
  - At most one command outstanding.
  - A rsp_valid while no command is outstanding is ignored.
- States:
  - IDLE: on start → POLL_REQ.
  - POLL_REQ: read STATUS_ADDR; on accept → POLL_WAIT.
  - POLL_WAIT: on rsp:
    - rsp_data[3] = 1 → latch status word, set subpage = rsp_data[0], index = 0 → READ_REQ.
    - rsp_data[3] = 0 → GAP.
  - GAP: count POLL_GAP cycles → POLL_REQ.
  - READ_REQ: read RAM_BASE + index; on accept → READ_WAIT.
  - READ_WAIT: on rsp, pix_valid = 1 the same cycle as rsp_valid (0-cycle latency), with pix_index = index and pix_data = rsp_data.
    - index == WORDS-1 → CLR_REQ.
    - otherwise index += 1 → READ_REQ.
  - CLR_REQ: write STATUS_ADDR with latched status & 16'hFFF7; on accept → CLR_WAIT.
  - CLR_WAIT: on rsp → frame_done pulse next cycle → IDLE.
- Error handling:
  - rsp_nack = 1 in any *_WAIT: error pulse, no pix_valid for that word, → IDLE.
  - Timeout counter resets on command acceptance and counts in *_WAIT. Reaching RSP_TIMEOUT → error pulse → IDLE. A late response after timeout is ignored.
- Abort:
  - In IDLE, GAP or *_REQ: immediate → IDLE, and cmd_valid drops.
  - A *_REQ aborted while cmd_ready is high in the same cycle counts as accepted → wait state, then IDLE after the response.
  - In *_WAIT: wait for the response, suppress pix_valid and frame_done → IDLE.
  - Abort never pulses error.
- Priority within a cycle: reset > rsp_nack/timeout > abort > normal progress.
- start while busy: ignored, not queued.
- The pixel sink has no backpressure; it must accept every pix_valid.
- Sustained throughput is one word per I2C transaction; the sequencer adds no more than 1 idle cycle between a response and the next cmd_valid.

Test Plan:
- Data already ready:
  - Stimulus: start; status read returns 16'h0009; I2C model with 3-cycle accept and 10-cycle response.
  - Required: 832 pix_valid pulses, indices 0..831, addresses 0x0400..0x073F; subpage = 1; final write reg 0x8000 data 0x0001; one frame_done; 834 commands total.
- Polling:
  - Stimulus: status returns 0x0000 twice, then 0x0008; POLL_GAP = 5.
  - Required: three status reads, with ≥5 idle cycles between each read's response and the next cmd_valid; subpage = 0; frame completes.
- NACK mid-frame:
  - Stimulus: rsp_nack on the read of word 100.
  - Required: exactly 100 pix_valid pulses, error pulse, busy = 0 next cycle, no clear write.
- Timeout:
  - Stimulus: RSP_TIMEOUT = 50; drop the response to the word-5 read; deliver it late at cycle 80.
  - Required: error pulse 50 cycles after acceptance; late response ignored; no pix_valid for word 5.
- Abort in READ_WAIT:
  - Stimulus: abort at word 10.
  - Required: word 10 response consumed without pix_valid; then IDLE, no error, no frame_done.
  - Follow-up: a new start runs a full frame.
- Reset and start-while-busy:
  - Stimulus: assert rst_n low mid-frame.
  - Required: all outputs 0 asynchronously, state IDLE.
  - Stimulus: start pulse during GAP.
  - Required: ignored; exactly one frame_done.
